// File: rtl/zlib_byte_serializer.sv
// Buffers 32-bit zlib bitstream words in a small FIFO and serializes them MSB-byte-first
// onto a valid/ready byte stream. Optional running PNG CRC-32 output under `ZLIB_SER_CRC32_EN.
module zlib_byte_serializer #(
   parameter int DATA_WD    = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WD     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               val_i,
   input  logic [DATA_WD-1:0] dat_i,
   input  logic               done_i,
   output logic               byte_val_o,
   output logic [7:0]         byte_o,
   input  logic               byte_rdy_i,
   output logic               done_o,
   output logic               ovf_o,
   output logic [CNT_WD-1:0]  cnt_byte_o
`ifdef ZLIB_SER_CRC32_EN
   ,
   output logic [31:0]        crc_o
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);
   localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state, state_nxt;

   logic [DATA_WD-1:0] mem_p0 [FIFO_DEPTH];
   logic [AW:0]        wr_ptr_p0, rd_ptr_p0;
   logic               empty_p0, full_p0;
   logic               wr_en, pop, xfer, ovf_set;

   logic [DATA_WD-1:0] word_p1;
   logic [1:0]         idx_p1;
   logic [7:0]         byte_p1;
   logic               vld_p1;
   logic               ovf_q;
   logic [CNT_WD-1:0]  cnt_q;

   function automatic logic [7:0] sel_byte(input logic [DATA_WD-1:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    sel_byte = w[31:24];
         2'd1:    sel_byte = w[23:16];
         2'd2:    sel_byte = w[15:8];
         default: sel_byte = w[7:0];
      endcase
   endfunction

   assign empty_p0 = (wr_ptr_p0 == rd_ptr_p0);
   assign full_p0  = (wr_ptr_p0[AW] != rd_ptr_p0[AW]) &&
                     (wr_ptr_p0[AW-1:0] == rd_ptr_p0[AW-1:0]);

   // Holding register refills when idle or as its last byte leaves, so no bubble between words.
   assign xfer    = vld_p1 & byte_rdy_i;
   assign pop     = !empty_p0 && (!vld_p1 || (xfer && idx_p1 == 2'd3));
   assign wr_en   = val_i && (state == RUN) && (!full_p0 || pop);
   assign ovf_set = val_i && (state == RUN) && full_p0 && !pop;

   // ---- FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---- FSM: next state
   always_comb begin
      state_nxt = state;
      if (start_i) begin
         state_nxt = RUN;
      end else begin
         case (state)
            RUN:     if (done_i) state_nxt = DRAIN;
            DRAIN:   if (empty_p0 && !vld_p1) state_nxt = IDLE;
            default: state_nxt = state;
         endcase
      end
   end

   // ---- FSM: outputs
   always_comb begin
      done_o = 1'b0;
      if (state == DRAIN && empty_p0 && !vld_p1) done_o = 1'b1;
   end

   // ---- Stage p0: word FIFO storage
   always_ff @(posedge clk) begin
      if (wr_en) mem_p0[wr_ptr_p0[AW-1:0]] <= dat_i;
   end

   always_ff @(posedge clk) begin
      if (pop) word_p1 <= mem_p0[rd_ptr_p0[AW-1:0]];
   end

   // ---- Stage p1: byte holding register and stream control
   always_ff @(posedge clk) begin
      if (rst || start_i) begin
         wr_ptr_p0 <= '0;
         rd_ptr_p0 <= '0;
         vld_p1    <= 1'b0;
         byte_p1   <= 8'h00;
         idx_p1    <= 2'd0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if (wr_en) wr_ptr_p0 <= wr_ptr_p0 + PTR_ONE;
         if (pop)   rd_ptr_p0 <= rd_ptr_p0 + PTR_ONE;
         if (pop) begin
            vld_p1  <= 1'b1;
            idx_p1  <= 2'd0;
            byte_p1 <= sel_byte(mem_p0[rd_ptr_p0[AW-1:0]], 2'd0);
         end else if (xfer) begin
            if (idx_p1 == 2'd3) begin
               vld_p1 <= 1'b0;
            end else begin
               idx_p1  <= idx_p1 + 2'd1;
               byte_p1 <= sel_byte(word_p1, idx_p1 + 2'd1);
            end
         end
         if (ovf_set) ovf_q <= 1'b1;
         if (xfer)    cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign byte_val_o = vld_p1;
   assign byte_o     = byte_p1;
   assign ovf_o      = ovf_q;
   assign cnt_byte_o = cnt_q;

`ifdef ZLIB_SER_CRC32_EN
   logic [31:0] crc_p1;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      crc32_byte = c;
   endfunction

   // Running register holds the un-inverted CRC; the inversion yields 0 for an empty stream.
   always_ff @(posedge clk) begin
      if (rst || start_i) crc_p1 <= 32'hFFFFFFFF;
      else if (xfer)      crc_p1 <= crc32_byte(crc_p1, byte_p1);
   end

   assign crc_o = ~crc_p1;
`endif

endmodule

// File: tb/tb_zlib_byte_serializer.sv
// Scoreboard bench for zlib_byte_serializer: expected bytes queued at stimulus time,
// a negedge monitor pops and compares on every handshake.
module tb_zlib_byte_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        val_i;
   logic [31:0] dat_i;
   logic        done_i;
   logic        byte_val_o;
   logic [7:0]  byte_o;
   logic        byte_rdy_i;
   logic        done_o;
   logic        ovf_o;
   logic [31:0] cnt_byte_o;
`ifdef ZLIB_SER_CRC32_EN
   logic [31:0] crc_o;
`endif

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int vld_seen = 0;
   logic [7:0] exp_q[$];
   logic       hold_pending = 1'b0;
   logic [7:0] hold_byte = 8'h00;

   zlib_byte_serializer #(.DATA_WD(32), .FIFO_DEPTH(8), .CNT_WD(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
      .done_i(done_i), .byte_val_o(byte_val_o), .byte_o(byte_o),
      .byte_rdy_i(byte_rdy_i), .done_o(done_o), .ovf_o(ovf_o),
      .cnt_byte_o(cnt_byte_o)
`ifdef ZLIB_SER_CRC32_EN
      , .crc_o(crc_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
   endtask

   task automatic wait_done(input int prev, input int maxc);
      int n = 0;
      while (done_cnt == prev && n < maxc) begin
         @(negedge clk); #1;
         n++;
      end
      chk("done_pulse_seen", done_cnt - prev, 1);
   endtask

   // Monitor: handshake byte compare, stall stability, done accounting
   always @(negedge clk) begin
      if (!rst) begin
         if (byte_val_o) vld_seen++;
         if (hold_pending && byte_val_o) chk("stall_stable", {24'h0, byte_o}, {24'h0, hold_byte});
         hold_pending = byte_val_o && !byte_rdy_i;
         hold_byte    = byte_o;
         if (byte_val_o && byte_rdy_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL byte_unexpected: got %h expected none", byte_o);
            end else begin
               chk("byte", {24'h0, byte_o}, {24'h0, exp_q.pop_front()});
            end
         end
         if (done_o) begin
            done_cnt++;
            chk("done_queue_empty", exp_q.size(), 0);
         end
      end
   end

   initial begin
      int prev, v0;
      logic [31:0] w3 [3];
      rst = 1'b1; start_i = 1'b0; val_i = 1'b0; dat_i = '0; done_i = 1'b0; byte_rdy_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_byte_val", {31'h0, byte_val_o}, 0);
      chk("rst_byte", {24'h0, byte_o}, 0);
      chk("rst_done", {31'h0, done_o}, 0);
      chk("rst_ovf", {31'h0, ovf_o}, 0);
      chk("rst_cnt", cnt_byte_o, 0);
`ifdef ZLIB_SER_CRC32_EN
      chk("rst_crc", crc_o, 32'h0);
`endif
      rst = 1'b0;

      // 1: single word with done_i in the same cycle
      pulse_start();
      val_i = 1'b1; dat_i = 32'h78DA0102; done_i = 1'b1; byte_rdy_i = 1'b1;
      push_word(32'h78DA0102);
      @(posedge clk); #1 val_i = 1'b0; done_i = 1'b0;
      chk("t1_lat_early", {31'h0, byte_val_o}, 0);
      @(posedge clk); #1;
      chk("t1_lat_valid", {31'h0, byte_val_o}, 1);
      chk("t1_first_byte", {24'h0, byte_o}, 32'h78);
      repeat (4) @(posedge clk);
      #1;
      chk("t1_done", {31'h0, done_o}, 1);
      chk("t1_cnt", cnt_byte_o, 4);
      @(posedge clk); #1;
      chk("t1_done_1cyc", {31'h0, done_o}, 0);

      // 2: three words back to back, ready toggling
      pulse_start();
      prev = done_cnt;
      w3[0] = 32'h12345678; w3[1] = 32'h9ABCDEF0; w3[2] = 32'h0055AA11;
      for (int i = 0; i < 3; i++) push_word(w3[i]);
      for (int i = 0; i < 60; i++) begin
         byte_rdy_i = (i % 2) == 0;
         val_i  = (i < 3);
         dat_i  = (i < 3) ? w3[i] : 32'h0;
         done_i = (i == 2);
         @(posedge clk); #1;
      end
      val_i = 1'b0; done_i = 1'b0;
      chk("t2_done_count", done_cnt - prev, 1);
      chk("t2_cnt", cnt_byte_o, 12);

      // 3: overflow with downstream stalled
      byte_rdy_i = 1'b0;
      pulse_start();
      prev = done_cnt;
      for (int i = 0; i < 10; i++) begin
         logic [7:0] k;
         k = 8'(i);
         val_i = 1'b1;
         dat_i = {8'hA0 + k, 8'hB0 + k, 8'hC0 + k, 8'hD0 + k};
         if (i < 9) push_word(dat_i);
         @(posedge clk); #1;
         if (i == 8) chk("t3_no_ovf_at_9", {31'h0, ovf_o}, 0);
      end
      chk("t3_ovf_at_10", {31'h0, ovf_o}, 1);
      val_i = 1'b0; done_i = 1'b1;
      @(posedge clk); #1 done_i = 1'b0; byte_rdy_i = 1'b1;
      wait_done(prev, 80);
      chk("t3_ovf_sticky", {31'h0, ovf_o}, 1);
      chk("t3_cnt", cnt_byte_o, 36);

      // 4: empty stream
      pulse_start();
      chk("t4_ovf_cleared", {31'h0, ovf_o}, 0);
      prev = done_cnt; v0 = vld_seen;
      done_i = 1'b1;
      @(posedge clk); #1 done_i = 1'b0;
      wait_done(prev, 10);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_done_once", done_cnt - prev, 1);
      chk("t4_no_valid", vld_seen - v0, 0);
      chk("t4_cnt", cnt_byte_o, 0);

      // 5: abort mid-drain, then a normal stream
      pulse_start();
      byte_rdy_i = 1'b1;
      push_word(32'hC1C2C3C4); push_word(32'hD1D2D3D4);
      val_i = 1'b1; dat_i = 32'hC1C2C3C4;
      @(posedge clk); #1 dat_i = 32'hD1D2D3D4; done_i = 1'b1;
      @(posedge clk); #1 val_i = 1'b0; done_i = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      start_i = 1'b1; byte_rdy_i = 1'b0;
      prev = done_cnt;
      @(posedge clk); #1 start_i = 1'b0;
      chk("t5_abort_valid", {31'h0, byte_val_o}, 0);
      chk("t5_abort_cnt", cnt_byte_o, 0);
      chk("t5_bytes_left", exp_q.size(), 6);
      exp_q.delete();
      byte_rdy_i = 1'b1;
      push_word(32'h5A5B5C5D);
      val_i = 1'b1; dat_i = 32'h5A5B5C5D; done_i = 1'b1;
      @(posedge clk); #1 val_i = 1'b0; done_i = 1'b0;
      wait_done(prev, 20);
      chk("t5_cnt", cnt_byte_o, 4);

`ifdef ZLIB_SER_CRC32_EN
      // 6: CRC of "IEND"
      pulse_start();
      chk("t6_crc_start", crc_o, 32'h0);
      prev = done_cnt;
      push_word(32'h49454E44);
      val_i = 1'b1; dat_i = 32'h49454E44; done_i = 1'b1;
      @(posedge clk); #1 val_i = 1'b0; done_i = 1'b0;
      wait_done(prev, 20);
      chk("t6_crc_iend", crc_o, 32'hAE426082);
`endif

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
